ov7670_capture_dec80x60: RTL
============================

// Module: ov7670_capture_dec80x60
// PURPOSE
//  Upstream write stage of the 80x60x12b frame buffer. Parses the OV7670 RGB444 byte stream:
//  640x480, 2 bytes/pixel, first byte xxxxRRRR, second byte GGGGBBBB.
//  Point-decimates the stream by 8 in x and y, and drives the buffer write port (wea/addra/dina).
//  Camera signals arrive already synchronised to clk, qualified by a one-cycle pclk strobe.
// PARAMETERS
//  C_IN_COLS    640  input pixels per line
//  C_IN_ROWS    480  input lines per frame
//  C_DEC_SHIFT  3    log2 decimation factor (8)
//  C_IMG_COLS   80   output columns (C_IN_COLS>>C_DEC_SHIFT)
//  C_IMG_ROWS   60   output rows
//  C_NB_ADDR    13   write address width (4800 < 2^13)
// PORTS
//  clk          in   1   system clock; single clock domain
//  rst          in   1   asynchronous, active-high reset
//  cam_pclk_en  in   1   1-cycle strobe per camera PCLK rising edge; all cam_* sampled only when high
//  cam_vsync    in   1   OV7670 VSYNC (high = vertical blank)
//  cam_href     in   1   OV7670 HREF (high = valid bytes on line)
//  cam_data     in   8   OV7670 D[7:0]
//  cap_en       in   1   capture enable; sampled at frame start only
//  wea          out  1   buffer write enable, 1-cycle pulse
//  addra        out  13  buffer write address = row_o*80 + col_o
//  dina         out  12  RGB444 pixel {R,G,B}
//  frame_done   out  1   1-cycle pulse at end of a captured frame
//  busy         out  1   high while in S_CAPT
// BEHAVIOUR
//  - Reset values: wea=0, addra=0, dina=0, frame_done=0, busy=0. State=S_WAIT_VS. All counters 0.
//  - Only strobes with cam_pclk_en=1 advance any state. Other cycles hold state; wea/frame_done forced 0.
//  - FSM:
//    S_WAIT_VS: wait for vsync=1, then go to S_WAIT_FR.
//    S_WAIT_FR: on vsync=0, go to S_CAPT if cap_en=1, else back to S_WAIT_VS. Clear col/row/phase.
//    S_CAPT: on vsync=1, pulse frame_done and go to S_WAIT_FR.
//  - Byte phase (S_CAPT, href=1): phase 0 latches R=data[3:0]. Phase 1 forms pixel {R,data[7:4],data[3:0]}
//    and increments col (10b).
//  - Write: on phase 1, if col[2:0]==0 && row[2:0]==0 && col<640 && row<480:
//    wea=1 the next clk cycle, addra=(row>>3)*80+(col>>3), dina=pixel.
//    Latency is 1 clk from the strobe; no write otherwise.
//  - Address arithmetic: (row>>3)*64 + (row>>3)*16 + (col>>3), 13b, no multiplier. Max value 4799.
//  - Line end: on an href 1->0 transition with col>0, row increments; col and phase reset.
//    An odd byte (phase 1 pending) is discarded.
//  - Overflow: pixels with col>=640 and lines with row>=480 are ignored. Counters saturate; no wrap into valid addresses.
//  - vsync rising mid-line ends the frame immediately: frame_done pulses and the partial line is dropped.
//  - href high while vsync=1, or outside S_CAPT: ignored.
//  - Reset mid-frame: return to S_WAIT_VS. Capture resumes only after a complete vsync high->low.
//    A partial frame is never written.
//  - cap_en change mid-frame has no effect until the next frame start.
// CONFIGURATION
//  CAPTURE_TESTPAT_EN defined:
//    - Adds input test_pat (1b).
//    - When test_pat=1, dina = {col[6:3], row[6:3], col[6:3]^row[6:3]}; timing and addresses unchanged.
//  CAPTURE_TESTPAT_EN undefined:
//    - No test_pat port; dina is always camera data.
// TESTING
//  1. rst high, then low; no strobes -> all outputs 0, busy=0 for 100 cycles.
//  2. Full frame 640x480, pixel(x,y)={x[3:0],y[3:0],4'hA}, cap_en=1:
//     -> exactly 4800 writes; addr 0 dina=12'h00A; addr 81 dina=12'h88A;
//     addr 4799 dina=12'h88A (x=632,y=472); one frame_done.
//  3. cap_en=0 at vsync fall -> zero writes, busy=0 for the frame, no frame_done.
//  4. Lines of 700 pixels and 500 lines -> still 4800 writes, max addra=4799, no address >4799.
//  5. vsync rises at row 100 -> frame_done pulse; last write address <= 12*80+79=1039.
//     Next frame starts at addr 0.
//  6. rst pulse at row 200 -> no writes until the next vsync high->low; the following frame gives 4800 writes.

Source files
------------

// File: rtl/ov7670_capture_dec80x60_if.sv
// Camera byte stream plus frame-buffer write port for ov7670_capture_dec80x60.
// test_pat is present only when CAPTURE_TESTPAT_EN is defined.
interface ov7670_capture_dec80x60_if;
  localparam int unsigned C_NB_ADDR = 13;
  localparam int unsigned C_NB_PIX  = 12;

  logic                 cam_pclk_en;
  logic                 cam_vsync;
  logic                 cam_href;
  logic [7:0]           cam_data;
  logic                 cap_en;
`ifdef CAPTURE_TESTPAT_EN
  logic                 test_pat;
`endif
  logic                 wea;
  logic [C_NB_ADDR-1:0] addra;
  logic [C_NB_PIX-1:0]  dina;
  logic                 frame_done;
  logic                 busy;

`ifdef CAPTURE_TESTPAT_EN
  modport master (input cam_pclk_en, cam_vsync, cam_href, cam_data, cap_en, test_pat,
                  output wea, addra, dina, frame_done, busy);
  modport slave  (output cam_pclk_en, cam_vsync, cam_href, cam_data, cap_en, test_pat,
                  input wea, addra, dina, frame_done, busy);
`else
  modport master (input cam_pclk_en, cam_vsync, cam_href, cam_data, cap_en,
                  output wea, addra, dina, frame_done, busy);
  modport slave  (output cam_pclk_en, cam_vsync, cam_href, cam_data, cap_en,
                  input wea, addra, dina, frame_done, busy);
`endif
endinterface

// File: rtl/ov7670_capture_dec80x60.sv
// OV7670 RGB444 capture, point-decimated by 8 in x and y into the 80x60x12b buffer write port.
// Optional CAPTURE_TESTPAT_EN adds a test_pat input that replaces pixel data with a grid pattern.
module ov7670_capture_dec80x60 (
  input  logic                      clk,
  input  logic                      rst,
  ov7670_capture_dec80x60_if.master bus
);
  localparam int unsigned C_IN_COLS   = 640;
  localparam int unsigned C_IN_ROWS   = 480;
  localparam int unsigned C_DEC_SHIFT = 3;
  localparam int unsigned C_NB_ADDR   = 13;
  localparam int unsigned C_NB_PIX    = 12;
  localparam int unsigned C_NB_COL    = 10;
  localparam int unsigned C_NB_ROW    = 9;
  localparam logic [C_NB_COL-1:0] COL_LIM = C_NB_COL'(C_IN_COLS);
  localparam logic [C_NB_ROW-1:0] ROW_LIM = C_NB_ROW'(C_IN_ROWS);

  typedef enum logic [1:0] {S_WAIT_VS, S_WAIT_FR, S_CAPT} state_t;

  state_t                state_q, state_d;
  logic [C_NB_COL-1:0]   col_q, col_d;
  logic [C_NB_ROW-1:0]   row_q, row_d;
  logic                  phase_q, phase_d;
  logic                  href_q, href_d;
  logic [3:0]            red_q, red_d;
  logic                  wea_q, wea_d;
  logic [C_NB_ADDR-1:0]  addr_q, addr_d;
  logic [C_NB_PIX-1:0]   dina_q, dina_d;
  logic                  fd_q, fd_d;
  logic                  busy_q, busy_d;

  logic [C_NB_COL-C_DEC_SHIFT-1:0] col_blk;
  logic [C_NB_ROW-C_DEC_SHIFT-1:0] row_blk;
  logic [C_NB_ADDR-1:0]            addr_c;
  logic [C_NB_PIX-1:0]             pix_c;
  logic                            col_in, row_in, on_grid;

  // row_blk*80 built as row_blk*64 + row_blk*16
  assign col_blk = col_q[C_NB_COL-1:C_DEC_SHIFT];
  assign row_blk = row_q[C_NB_ROW-1:C_DEC_SHIFT];
  assign addr_c  = C_NB_ADDR'({row_blk, 6'b0}) + C_NB_ADDR'({row_blk, 4'b0}) + C_NB_ADDR'(col_blk);
  assign col_in  = (col_q < COL_LIM);
  assign row_in  = (row_q < ROW_LIM);
  assign on_grid = (col_q[C_DEC_SHIFT-1:0] == '0) && (row_q[C_DEC_SHIFT-1:0] == '0) && col_in && row_in;

  always_comb begin
`ifdef CAPTURE_TESTPAT_EN
    pix_c = bus.test_pat ? {col_q[6:3], row_q[6:3], col_q[6:3] ^ row_q[6:3]}
                         : {red_q, bus.cam_data};
`else
    pix_c = {red_q, bus.cam_data};
`endif
  end

  always_comb begin
    state_d = state_q;
    col_d   = col_q;
    row_d   = row_q;
    phase_d = phase_q;
    href_d  = href_q;
    red_d   = red_q;
    wea_d   = 1'b0;
    fd_d    = 1'b0;
    addr_d  = addr_q;
    dina_d  = dina_q;
    if (bus.cam_pclk_en) begin
      unique case (state_q)
        S_WAIT_VS: if (bus.cam_vsync) state_d = S_WAIT_FR;
        S_WAIT_FR: begin
          col_d   = '0;
          row_d   = '0;
          phase_d = 1'b0;
          href_d  = 1'b0;
          if (!bus.cam_vsync) state_d = bus.cap_en ? S_CAPT : S_WAIT_VS;
        end
        S_CAPT: begin
          if (bus.cam_vsync) begin
            fd_d    = 1'b1;
            state_d = S_WAIT_FR;
          end else begin
            href_d = bus.cam_href;
            if (bus.cam_href) begin
              if (!phase_q) begin
                red_d   = bus.cam_data[3:0];
                phase_d = 1'b1;
              end else begin
                phase_d = 1'b0;
                if (col_in) col_d = col_q + 1'b1;
                if (on_grid) begin
                  wea_d  = 1'b1;
                  addr_d = addr_c;
                  dina_d = pix_c;
                end
              end
            end else if (href_q) begin
              // line end: a half-received pixel is dropped, empty lines do not count
              col_d   = '0;
              phase_d = 1'b0;
              if ((col_q != '0) && row_in) row_d = row_q + 1'b1;
            end
          end
        end
        default: state_d = S_WAIT_VS;
      endcase
    end
    busy_d = (state_d == S_CAPT);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_WAIT_VS;
      col_q   <= '0;
      row_q   <= '0;
      phase_q <= 1'b0;
      href_q  <= 1'b0;
      red_q   <= '0;
      wea_q   <= 1'b0;
      addr_q  <= '0;
      dina_q  <= '0;
      fd_q    <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      col_q   <= col_d;
      row_q   <= row_d;
      phase_q <= phase_d;
      href_q  <= href_d;
      red_q   <= red_d;
      wea_q   <= wea_d;
      addr_q  <= addr_d;
      dina_q  <= dina_d;
      fd_q    <= fd_d;
      busy_q  <= busy_d;
    end
  end

  assign bus.wea        = wea_q;
  assign bus.addra      = addr_q;
  assign bus.dina       = dina_q;
  assign bus.frame_done = fd_q;
  assign bus.busy       = busy_q;
endmodule
